// File: rtl/pb_pkg.sv
// Shared types for the protobuf field byte path.
// Packed-field geometry and the streamer state encoding.
package pb_pkg;

  localparam int PF_IN_BYTES = 15;
  localparam int PF_TAG_MAX  = 5;
  localparam int PF_VAL_MAX  = 10;

  typedef enum logic {
    IDLE,
    EMIT
  } stream_state_t;

  typedef logic [8*PF_IN_BYTES-1:0] packed_field_t;

endpackage

// File: rtl/pb_varint_len.sv
// Combinational byte length of a packed tag+value varint field.
// Flags err when either varint lacks a terminator byte.
module pb_varint_len
  import pb_pkg::*;
#(
  parameter int IN_BYTES = PF_IN_BYTES,
  parameter int TAG_MAX  = PF_TAG_MAX
) (
  input  logic [8*IN_BYTES-1:0] in_data,
  output logic [3:0]            len,
  output logic                  err
);

  logic [IN_BYTES-1:0] cont;
  logic                tag_hit;
  logic [3:0]          tag_len;
  logic                val_hit;
  logic                unused_bits;

  // Only the continuation bits matter here.
  assign unused_bits = ^in_data;

  always_comb begin
    cont = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      cont[i] = in_data[8*i+7];
    end
  end

  always_comb begin
    tag_hit = 1'b0;
    tag_len = 4'd0;
    for (int i = 0; i < TAG_MAX; i++) begin
      if (!tag_hit && !cont[i]) begin
        tag_hit = 1'b1;
        tag_len = 4'(i + 1);
      end
    end
  end

  always_comb begin
    val_hit = 1'b0;
    len     = 4'(IN_BYTES);
    for (int i = 1; i < IN_BYTES; i++) begin
      if (tag_hit && !val_hit &&
          4'(i) >= tag_len && !cont[i]) begin
        val_hit = 1'b1;
        len     = 4'(i + 1);
      end
    end
    err = !val_hit;
  end

endmodule

// File: rtl/pb_field_byte_streamer.sv
// Streams one packed varint field per handshake, a byte per cycle.
// PB_STREAM_BYTECOUNT_EN enables the running total_bytes counter.
module pb_field_byte_streamer
  import pb_pkg::*;
#(
  parameter int IN_BYTES = PF_IN_BYTES,
  parameter int TAG_MAX  = PF_TAG_MAX,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*IN_BYTES-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  busy,
  output logic [CNT_W-1:0]      total_bytes
);

  localparam int W = 8 * IN_BYTES;

  stream_state_t state;
  logic [W-1:0]  shreg;
  logic [3:0]    idx;
  logic [3:0]    len_q;
  logic          last_q;
  logic          err_q;
  logic [3:0]    len;
  logic          err;
  logic          accept;
  logic          fire;

  pb_varint_len #(
    .IN_BYTES (IN_BYTES),
    .TAG_MAX  (TAG_MAX)
  ) u_len (
    .in_data (in_data),
    .len     (len),
    .err     (err)
  );

  // A new field may load on the same cycle the last byte leaves.
  assign in_ready = (state == IDLE) || (last_q && out_ready);
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  assign out_byte = shreg[7:0];
  assign out_last = last_q;
  assign out_err  = err_q;
  assign busy     = (state == EMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= 4'd0;
      len_q     <= 4'd0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      state     <= EMIT;
      shreg     <= in_data;
      idx       <= 4'd0;
      len_q     <= len;
      last_q    <= (len == 4'd1);
      err_q     <= err;
      out_valid <= 1'b1;
    end else if (fire) begin
      if (last_q) begin
        state     <= IDLE;
        shreg     <= '0;
        idx       <= 4'd0;
        last_q    <= 1'b0;
        err_q     <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        shreg  <= shreg >> 8;
        idx    <= idx + 4'd1;
        last_q <= (idx + 4'd2 == len_q);
      end
    end
  end

`ifdef PB_STREAM_BYTECOUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (fire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign total_bytes = cnt;
`else
  assign total_bytes = '0;
`endif

endmodule

// File: tb/tb_pb_field_byte_streamer.sv
// Randomised and directed bench for pb_field_byte_streamer.
// Expected bytes come from a scan-based varint length model.
module tb_pb_field_byte_streamer;

  logic         clk;
  logic         rst;
  logic [119:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         out_err;
  logic         busy;
  logic [31:0]  total_bytes;

  pb_field_byte_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_err     (out_err),
    .busy        (busy),
    .total_bytes (total_bytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic       err;
  } exp_t;

  exp_t          eq[$];
  logic [119:0]  fq[$];
  int            checks = 0;
  int            errors = 0;
  int            nbytes = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_len(input logic [119:0] f,
                                 output bit e);
    int t;
    t = 0;
    e = 1'b1;
    for (int i = 0; i < 5; i++)
      if (t == 0 && f[8*i+7] == 1'b0) t = i + 1;
    if (t == 0) return 15;
    for (int i = t; i < 15; i++)
      if (f[8*i+7] == 1'b0) begin
        e = 1'b0;
        return i + 1;
      end
    return 15;
  endfunction

  function automatic void push_field(input logic [119:0] f);
    bit e;
    int n;
    exp_t x;
    n = ref_len(f, e);
    for (int i = 0; i < n; i++) begin
      x.b    = f[8*i +: 8];
      x.last = (i == n - 1);
      x.err  = e;
      eq.push_back(x);
    end
  endfunction

  function automatic logic [119:0] gen_field(input int kind);
    logic [119:0] f;
    logic [7:0]   b;
    int           tl;
    int           vl;
    f  = '0;
    tl = int'($urandom_range(1, 5));
    vl = int'($urandom_range(1, 10));
    for (int i = 0; i < 15; i++) begin
      b = 8'($urandom);
      if (kind == 0) begin
        b[7] = 1'b1;
        if (i == tl - 1 || i == tl + vl - 1) b[7] = 1'b0;
        if (i >= tl + vl) b = 8'h00;
      end else if (kind == 2 && i < 5) begin
        b[7] = 1'b1;
      end
      f[8*i +: 8] = b;
    end
    return f;
  endfunction

  function automatic logic [31:0] exp_total();
`ifdef PB_STREAM_BYTECOUNT_EN
    return 32'(nbytes);
`else
    return 32'd0;
`endif
  endfunction

  // mode 0: out_ready=1, 1: pattern 1,0,0,1, 2: random
  task automatic run(input int mode, input int gap);
    int  cyc;
    bit  hs;
    bit  acc;
    bit  eir;
    bit  started;
    int  bubbles;
    cyc     = 0;
    hs      = 0;
    acc     = 0;
    started = 0;
    bubbles = 0;
    while ((fq.size() != 0 || eq.size() != 0 || hs || acc)
           && cyc < 4000) begin
      @(negedge clk);
      if (hs) begin
        void'(eq.pop_front());
        nbytes++;
      end
      if (acc) begin
        push_field(fq.pop_front());
        in_valid = 1'b0;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = ($urandom_range(0, 99) < 65);
      endcase
      if (!in_valid && fq.size() != 0 &&
          (gap == 0 || $urandom_range(0, 99) >= gap)) begin
        in_valid = 1'b1;
        in_data  = fq[0];
      end
      #1;
      eir = (eq.size() == 0) || (eq[0].last && out_ready);
      chk("out_valid", out_valid, eq.size() != 0);
      chk("busy", busy, eq.size() != 0);
      chk("in_ready", in_ready, eir);
      if (eq.size() != 0) begin
        started = 1;
        chk("out_byte", out_byte, eq[0].b);
        chk("out_last", out_last, eq[0].last);
        chk("out_err", out_err, eq[0].err);
      end else if (started && fq.size() != 0) begin
        bubbles++;
      end
      hs  = (eq.size() != 0) && out_ready;
      acc = in_valid && eir;
      cyc++;
    end
    chk("timeout", cyc < 4000, 1'b1);
    if (mode == 0 && gap == 0) chk("bubbles", bubbles, 0);
    chk("total_bytes", total_bytes, exp_total());
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_byte", out_byte, 8'h00);
    chk("rst_total", total_bytes, 32'd0);
    rst = 1'b0;

    fq.push_back(120'h019608);
    run(0, 0);
    fq.push_back(120'h01FFFFFFFFFFFFFFFFFE10);
    run(0, 0);
    fq.push_back(120'h0310);
    fq.push_back(120'h019608);
    run(0, 0);
    fq.push_back(120'h019608);
    run(1, 0);
    fq.push_back({15{8'hFF}});
    run(0, 0);
    fq.push_back(120'h0B_0000_0000);
    run(1, 0);

    @(negedge clk);
    in_data   = 120'h01FFFFFFFFFFFFFFFFFE10;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rs_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rs_byte0", out_byte, 8'h10);
    @(negedge clk);
    #1;
    chk("rs_byte1", out_byte, 8'hFE);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rs_byte2", out_byte, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rs_out_valid", out_valid, 1'b0);
    chk("rs_in_ready2", in_ready, 1'b1);
    chk("rs_total", total_bytes, 32'd0);
    chk("rs_busy", busy, 1'b0);
    nbytes = 0;
    eq.delete();
    fq.push_back(120'h019608);
    run(0, 0);

    repeat (30) fq.push_back(gen_field(int'($urandom_range(0, 2))));
    run(0, 0);
    repeat (30) fq.push_back(gen_field(int'($urandom_range(0, 2))));
    run(2, 30);
    repeat (20) fq.push_back(gen_field(0));
    run(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_field_byte_streamer.md
Name: pb_field_byte_streamer

Overview:
- Downstream of the varint field encoder, which produces a 120-bit packed field: tag varint followed immediately by value varint.
- This block accepts one packed field per valid/ready handshake and measures its true byte length from the varint continuation bits.
- It emits the field one byte per cycle on a valid/ready byte stream, with a last flag on the final byte of each field.
- It feeds the output message buffer and framing logic.

Parameters:
- IN_BYTES, 15, bytes in the packed input: 5 tag + 10 value.
- TAG_MAX, 5, maximum tag varint length in bytes.
- CNT_W, 32, width of the running byte counter (optional feature only).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_data  input  8*IN_BYTES  packed field; wire byte i at [8i+7:8i], byte 0 sent first; unused high bytes are zero
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept in_data this cycle
- out_byte  output  8  current stream byte
- out_valid  output  1  out_byte valid
- out_ready  input  1  consumer accepts out_byte
- out_last  output  1  out_byte is the final byte of the field
- out_err  output  1  current field is malformed; valid while out_valid
- busy  output  1  field in flight (state EMIT)
- total_bytes  output  CNT_W  running count of emitted bytes (optional feature)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_last=0, out_err=0, busy=0, total_bytes=0, out_byte=0, internal shift register and counters 0.
- Reset during EMIT abandons the field with no further bytes, including when asserted mid-handshake.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: out_valid=1, out_byte=shreg[7:0].
- Accept: in_valid&&in_ready captures in_data into shreg and computes len and err combinationally from in_data. The block enters EMIT next cycle, so the first byte is visible 1 cycle after accept.
- Length rule:
  - tag_len = 1 + index of the first byte in 0..TAG_MAX-1 with bit7=0.
  - val_len = 1 + offset of the first byte at index >= tag_len with bit7=0, searched up to byte IN_BYTES-1.
  - len = tag_len + val_len (range 2..15).
- Malformed: no tag terminator within TAG_MAX bytes, or no value terminator by byte 14. Then len=IN_BYTES, err=1, and all 15 bytes are emitted with out_err=1 on every byte.
- Emit handshake: on out_valid&&out_ready, shreg shifts right 8 and idx increments. out_last = (idx==len-1).
- Backpressure: while out_ready=0, out_byte, out_last and out_err hold stable.
- Zero-bubble chaining: in_ready = IDLE || (out_last && out_ready). A new field accepted on the last-byte handshake reloads shreg, so its first byte appears the next cycle. With no new field, the block returns to IDLE.
- in_valid is ignored while in_ready=0. The upstream stage must hold data (standard valid/ready).

Optional Feature:
- Macro PB_STREAM_BYTECOUNT_EN.
- Defined: total_bytes increments by 1 on every out handshake and wraps modulo 2^CNT_W. It is cleared only by rst. Used for length-delimited submessage framing.
- Undefined: counter logic is absent and total_bytes is tied to 0. The port still exists.

Decomposition:
- Shared package pb_pkg:
  - localparams for packed width (IN_BYTES=15, TAG_MAX=5, VAL_MAX=10).
  - enum stream_state_t {IDLE, EMIT}.
  - typedef packed_field_t logic [119:0].
- One natural sub-module: pb_varint_len. It is purely combinational: in_data -> len[3:0], err. It is reused later by the decoder path.

Test Plan:
- in_data=120'h019608 (field 1 varint 150), out_ready=1 -> bytes 08,96,01 on 3 consecutive cycles. out_last only on 01; out_err=0.
- in_data = tag 0x10 + int64 -2 (FE FF FF FF FF FF FF FF FF 01) -> 11 bytes 10,FE..FF,01. out_last on byte 11.
- Two fields back-to-back (120'h0310, then 120'h019608) with in_valid held and out_ready=1 -> 10,03,08,96,01 with no bubble. in_ready is high on the cycle 03 transfers.
- Backpressure: out_ready toggled 1,0,0,1,... on field 120'h019608 -> out_byte holds 96 during stalls. No byte is lost or duplicated.
- Malformed: in_data all 0xFF -> 15 bytes of FF with out_err=1 throughout and out_last on the 15th byte.
- rst asserted after the 2nd byte of an 11-byte field -> next cycle out_valid=0, in_ready=1, total_bytes=0. A new field then streams correctly.
